// File: rtl/mouse_pkg.sv
// Shared types and widths for the PS/2 mouse block.
package mouse_pkg;

  localparam int MOUSE_W = 12;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} cfg_state_t;
  typedef enum logic [1:0] {STEP_MAX_X, STEP_MAX_Y, STEP_X, STEP_Y} cfg_step_t;

  // Start position clamped into [0, limit]; unsigned compare.
  function automatic logic [MOUSE_W-1:0] clamp_start(input logic [MOUSE_W-1:0] pos,
                                                     input logic [MOUSE_W-1:0] lim);
    return (pos > lim) ? lim : pos;
  endfunction

endpackage

// File: rtl/mouse_cfg_seq.sv
// Configuration sequencer: writes X limit, Y limit, start X, start Y into the
// mouse controller over a shared value bus with one-hot load strobes.
module mouse_cfg_seq
  import mouse_pkg::*;
#(
  parameter int GAP       = 4,   // hold cycles after each strobe, 1..15
  parameter int AUTO_INIT = 1    // 1: run one sequence right after reset
) (
  input  logic               clk100MHz,
  input  logic               rst,        // async, active low
  input  logic               cfg_req,
  input  logic [MOUSE_W-1:0] max_x,
  input  logic [MOUSE_W-1:0] max_y,
  input  logic [MOUSE_W-1:0] start_x,
  input  logic [MOUSE_W-1:0] start_y,
  output logic [MOUSE_W-1:0] value,
  output logic               setmax_x,
  output logic               setmax_y,
  output logic               setx,
  output logic               sety,
  output logic               busy,
  output logic               done
);

  localparam int              CNT_W     = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(GAP - 1);
  localparam bit              AUTO      = (AUTO_INIT != 0);

  cfg_state_t                     state_q;
  cfg_step_t                      step_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           pend_q;
  logic                           arm_q;    // first cycle after reset release
  logic [3:0][MOUSE_W-1:0]        snap_q;   // indexed by step
  logic [MOUSE_W-1:0]             value_q;
  logic [3:0]                     strb_q;   // one bit per step
  logic                           busy_q;
  logic                           done_q;

  logic      start_c;
  logic      pend_c;
  cfg_step_t step_nxt;

  // Start sources and request merging while a sequence is running.
  always_comb begin
    start_c  = cfg_req | pend_q | (AUTO & arm_q);
    pend_c   = pend_q | cfg_req;
    step_nxt = cfg_step_t'(step_q + 2'd1);
  end

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk100MHz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= STEP_MAX_X;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      arm_q   <= 1'b1;
      snap_q  <= '0;
      value_q <= '0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      arm_q  <= 1'b0;
      done_q <= 1'b0;
      strb_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (start_c) begin
            // Snapshot so later input changes cannot disturb this sequence.
            snap_q[STEP_MAX_X] <= max_x;
            snap_q[STEP_MAX_Y] <= max_y;
            snap_q[STEP_X]     <= clamp_start(start_x, max_x);
            snap_q[STEP_Y]     <= clamp_start(start_y, max_y);
            value_q <= max_x;
            step_q  <= STEP_MAX_X;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end else begin
            value_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        SETUP: begin
          pend_q         <= pend_c;
          strb_q[step_q] <= 1'b1;
          state_q        <= STROBE;
        end
        STROBE: begin
          pend_q  <= pend_c;
          cnt_q   <= HOLD_LAST;
          state_q <= HOLD;
        end
        HOLD: begin
          pend_q <= pend_c;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (step_q == STEP_Y) begin
            // A pending request keeps busy high through the done cycle.
            value_q <= '0;
            done_q  <= 1'b1;
            busy_q  <= pend_c;
            state_q <= IDLE;
          end else begin
            step_q  <= step_nxt;
            value_q <= snap_q[step_nxt];
            state_q <= SETUP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign value    = value_q;
  assign setmax_x = strb_q[STEP_MAX_X];
  assign setmax_y = strb_q[STEP_MAX_Y];
  assign setx     = strb_q[STEP_X];
  assign sety     = strb_q[STEP_Y];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mouse_cfg_seq.sv
// Bench for mouse_cfg_seq: two instances (GAP=4 auto-init, GAP=1 no auto-init)
// share stimulus; outputs compared each cycle against a timeline model.
module tb_mouse_cfg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_req = 1'b0;
  logic [11:0] max_x = 12'd1023, max_y = 12'd767, start_x = 12'd512, start_y = 12'd384;

  logic [1:0][11:0] val;
  logic [1:0][3:0]  stb;   // {sety, setx, setmax_y, setmax_x}
  logic [1:0]       bsy, dno;

  always #5 clk = ~clk;

  mouse_cfg_seq #(.GAP(4), .AUTO_INIT(1)) u0 (
    .clk100MHz(clk), .rst(rst), .cfg_req(cfg_req),
    .max_x(max_x), .max_y(max_y), .start_x(start_x), .start_y(start_y),
    .value(val[0]), .setmax_x(stb[0][0]), .setmax_y(stb[0][1]),
    .setx(stb[0][2]), .sety(stb[0][3]), .busy(bsy[0]), .done(dno[0]));

  mouse_cfg_seq #(.GAP(1), .AUTO_INIT(0)) u1 (
    .clk100MHz(clk), .rst(rst), .cfg_req(cfg_req),
    .max_x(max_x), .max_y(max_y), .start_x(start_x), .start_y(start_y),
    .value(val[1]), .setmax_x(stb[1][0]), .setmax_y(stb[1][1]),
    .setx(stb[1][2]), .sety(stb[1][3]), .busy(bsy[1]), .done(dno[1]));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a sequence is a timeline of 4*(G+2) cycles counted from its start.
  int          mg[2]   = '{4, 1};
  int          mauto[2] = '{1, 0};
  int          act[2], off[2], pend[2], mdn[2], arm[2];
  logic [11:0] snap[2][4];

  function automatic logic [11:0] umin(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; off[d] = 0; pend[d] = 0; mdn[d] = 0; arm[d] = 1;
      for (int k = 0; k < 4; k++) snap[d][k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int len = 4 * (mg[d] + 2);
      if (act[d] != 0) begin
        if (cfg_req) pend[d] = 1;
        mdn[d] = (off[d] == len);
        if (off[d] == len) act[d] = 0;
        else off[d]++;
      end else begin
        mdn[d] = 0;
        if (cfg_req || pend[d] != 0 || (arm[d] != 0 && mauto[d] != 0)) begin
          snap[d][0] = max_x;
          snap[d][1] = max_y;
          snap[d][2] = umin(start_x, max_x);
          snap[d][3] = umin(start_y, max_y);
          act[d] = 1; off[d] = 1; pend[d] = 0;
        end
      end
      arm[d] = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int ev = 0, es = 0, eb, k, ph;
      eb = (act[d] != 0 || pend[d] != 0);
      if (act[d] != 0) begin
        k  = (off[d] - 1) / (mg[d] + 2);
        ph = (off[d] - 1) % (mg[d] + 2);
        ev = snap[d][k];
        if (ph == 1) es = 1 << k;
      end
      chk($sformatf("d%0d.value", d), val[d], ev);
      chk($sformatf("d%0d.strobes", d), stb[d], es);
      chk($sformatf("d%0d.busy", d), bsy[d], eb);
      chk($sformatf("d%0d.done", d), dno[d], mdn[d]);
    end
    chk("d0.onehot", $onehot0(stb[0]), 1);
  endtask

  int dcnt0 = 0;

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check_all();
      dcnt0 += dno[0];
    end
  endtask

  task automatic pulse();
    cfg_req = 1'b1; run(1); cfg_req = 1'b0;
  endtask

  // Assert reset mid-cycle, verify asynchronous clear, hold, then release.
  task automatic rst_pulse(input int hold);
    rst = 1'b0;
    #1;
    mreset();
    check_all();
    run(hold);
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    mreset();
    // Reset state, then auto-init on u0 with the reference board size.
    run(3);
    rst = 1'b1;
    run(1);
    chk("auto_busy_after_1st_edge", bsy[0], 1);
    run(29);

    // Clamped starts, and a limit change mid-sequence that must not leak in.
    max_x = 12'd800; max_y = 12'd600; start_x = 12'd2000; start_y = 12'd5;
    pulse();
    run(4);
    max_x = 12'd100;
    run(30);

    // Three requests during busy merge into one extra sequence.
    max_x = 12'd321;
    dcnt0 = 0;
    pulse(); run(3); pulse(); run(4); pulse(); run(5); pulse(); run(50);
    chk("d0.done_pulses_merge", dcnt0, 2);

    // Reset landing on the setx strobe of u0.
    pulse();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run(1);
      if (act[0] != 0 && off[0] == 14) found = 1;
    end
    chk("setx_reached", found, 1);
    rst_pulse(3);
    run(40);

    // Zero limits force zero starts.
    max_x = 12'd0; max_y = 12'd0;
    start_x = 12'($urandom_range(1, 4095)); start_y = 12'($urandom_range(1, 4095));
    pulse();
    run(30);

    // Randomised traffic with occasional resets and long request levels.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        max_x   = 12'($urandom_range(0, 4095));
        max_y   = 12'($urandom_range(0, 4095));
        start_x = 12'($urandom_range(0, 4095));
        start_y = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 9) == 0) cfg_req = ~cfg_req;
      else if (cfg_req && $urandom_range(0, 1) == 0) cfg_req = 1'b0;
      if ($urandom_range(0, 299) == 0) rst_pulse($urandom_range(1, 3));
      else run(1);
    end
    cfg_req = 1'b0;
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
